// File: rtl/mem_pkg.sv
// mem_pkg: shared owner ids, FSM states and default widths for the memory arbiter.
package mem_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_HOST = 1'b1;
  typedef enum logic {S_SHARED = 1'b0, S_LOCK = 1'b1} state_e;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating starvation counter; forced is high once MAX_WAIT refusals accrue.
module arb_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  input  logic freeze,
  output logic forced
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (gnt || !req) ? '0 : (freeze || cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign forced = cnt_q == CNT_MAX;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single-port program/data RAM between the CPU datapath and the host port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_WAIT = 4,
  parameter bit RR_MODE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          host_lock,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
);
  state_e state_q, state_d;
  logic last_q, last_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic cpu_force, host_force, cpu_wins;
  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_cpu_wait (
    .clk(clk), .reset(reset), .req(cpu_req), .gnt(cpu_gnt),
    .freeze(state_q == S_LOCK), .forced(cpu_force)
  );
  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_host_wait (
    .clk(clk), .reset(reset), .req(host_req), .gnt(host_gnt),
    .freeze(1'b0), .forced(host_force)
  );
  // Starvation force overrides both round-robin and fixed priority.
  always_comb begin
    cpu_wins = cpu_force | (~host_force & RR_MODE & (last_q == OWNER_HOST));
    cpu_gnt = ~reset & (state_q == S_SHARED) & cpu_req & (~host_req | cpu_wins);
    host_gnt = ~reset & host_req & ((state_q == S_LOCK) | ~cpu_req | ~cpu_wins);
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_we = (cpu_gnt & cpu_we) | (host_gnt & host_we);
    mem_addr = cpu_gnt ? cpu_addr : host_gnt ? host_addr : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
    last_d = cpu_gnt ? OWNER_CPU : host_gnt ? OWNER_HOST : last_q;
    rvalid_d = {host_gnt & ~host_we, cpu_gnt & ~cpu_we};
    state_d = (state_q == S_LOCK) ? (host_lock ? S_LOCK : S_SHARED)
                                  : ((host_gnt & host_lock) ? S_LOCK : S_SHARED);
    cpu_rvalid = rvalid_q[0];
    host_rvalid = rvalid_q[1];
    cpu_rdata = rvalid_q[0] ? mem_rdata : '0;
    host_rdata = rvalid_q[1] ? mem_rdata : '0;
    locked = state_q == S_LOCK;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SHARED;
      last_q <= OWNER_HOST;
      rvalid_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rvalid_q <= rvalid_d;
    end
  end
endmodule
